// File: rtl/bullet_pool_pkg.sv
// Shared types and helpers for the projectile pool: direction enum, slot state,
// the 32-bit OAM state word layout and position/tile arithmetic.
package bullet_pool_pkg;

  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  typedef enum logic {S_IDLE = 1'b0, S_FLY = 1'b1} slot_state_e;

  localparam logic [1:0] OBJ_BULLET = 2'b01;
  localparam int COORD_W = 10;
  localparam int CALC_W  = COORD_W + 1;

  typedef struct packed {
    logic               flag;
    logic [1:0]         obj;
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    dir_e               dir;
    logic [2:0]         rsvd;
    logic [2:0]         dir_ext;
  } obj_state_t;

  function automatic logic [COORD_W-1:0] tile_of(input logic [COORD_W-1:0] p, input int log2);
    return p >> log2;
  endfunction

  // One step along d in CALC_W bits; moving below zero wraps to a huge value,
  // so a single ">= FIELD_MAX" compare catches both field edges.
  function automatic logic [2*CALC_W-1:0] step_pos(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                                   input dir_e d, input logic [CALC_W-1:0] s);
    logic [CALC_W-1:0] px, py;
    px = {1'b0, x};
    py = {1'b0, y};
    case (d)
      DIR_UP:   py = py - s;
      DIR_DOWN: py = py + s;
      DIR_LEFT: px = px - s;
      default:  px = px + s;
    endcase
    return {px, py};
  endfunction

  function automatic dir_e dir_rev(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/bullet_pool_if.sv
// Fire request handshake between the tank controller (master) and the pool (slave).
interface bullet_pool_if;
  logic       fire;
  logic [1:0] fire_dir;
  logic [9:0] init_x;
  logic [9:0] init_y;
  logic       fire_ack;

  modport master (output fire, fire_dir, init_x, init_y, input fire_ack);
  modport slave  (input fire, fire_dir, init_x, init_y, output fire_ack);
endinterface

// File: rtl/bullet_pool_slot.sv
// One projectile slot: IDLE/FLY FSM, step timer, position, target/wall/field checks.
// Optional BULLET_RICOCHET_EN: first wall hit reverses direction instead of retiring.
module bullet_slot
  import bullet_pool_pkg::*;
#(
  parameter int NUM_TARGETS = 2,
  parameter int STEP_PERIOD = 3,
  parameter int STEP_PX     = 32,
  parameter int TILE_LOG2   = 5,
  parameter int MAP_DIM     = 16,
  parameter int FIELD_MAX   = 480,
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           game_over,
  input  logic                           grant,
  input  dir_e                           init_dir,
  input  logic [COORD_W-1:0]             init_x,
  input  logic [COORD_W-1:0]             init_y,
  input  logic [NUM_TARGETS*COORD_W-1:0] tgt_x,
  input  logic [NUM_TARGETS*COORD_W-1:0] tgt_y,
  input  logic [MAP_DIM*MAP_DIM-1:0]     wall_map,
  output logic [NUM_TARGETS-1:0]         hit_vec,
  output logic                           fly_nxt,
  output obj_state_t                     word
);
  localparam int TW       = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int MAP_BITS = (MAP_DIM * MAP_DIM > 1) ? $clog2(MAP_DIM * MAP_DIM) : 1;
  localparam logic [CALC_W-1:0]  STEP   = CALC_W'(STEP_PX);
  localparam logic [CALC_W-1:0]  FMAX   = CALC_W'(FIELD_MAX);
  localparam logic [CALC_W-1:0]  BSZ    = CALC_W'(BULLET_SIZE);
  localparam logic [CALC_W-1:0]  TSZ    = CALC_W'(TANK_SIZE);
  localparam logic [COORD_W-1:0] MDIM   = COORD_W'(MAP_DIM);
  localparam logic [TW-1:0]      T_LAST = TW'(STEP_PERIOD - 1);

  slot_state_e          st;
  logic [COORD_W-1:0]   x, y;
  dir_e                 dir;
  logic [TW-1:0]        tmr;
  logic                 flag;

  logic                 run, tgt_hit, wall, step_now, oof, retire;
  logic [CALC_W-1:0]    nx, ny;
  logic [COORD_W-1:0]   tile_x, tile_y;
  logic [MAP_BITS-1:0]  idx;
`ifdef BULLET_RICOCHET_EN
  logic [CALC_W-1:0]    bx, by;
  logic                 bounce;
`endif

  always_comb begin
    run = (st == S_FLY) && !game_over;
    hit_vec = '0;
    for (int t = 0; t < NUM_TARGETS; t++) begin
      hit_vec[t] = run
        && ({1'b0, x} + BSZ > {1'b0, tgt_x[t*COORD_W +: COORD_W]})
        && ({1'b0, x} < {1'b0, tgt_x[t*COORD_W +: COORD_W]} + TSZ)
        && ({1'b0, y} + BSZ > {1'b0, tgt_y[t*COORD_W +: COORD_W]})
        && ({1'b0, y} < {1'b0, tgt_y[t*COORD_W +: COORD_W]} + TSZ);
    end
    tgt_hit  = |hit_vec;
    tile_x   = tile_of(x, TILE_LOG2);
    tile_y   = tile_of(y, TILE_LOG2);
    idx      = MAP_BITS'(tile_y * MDIM + tile_x);
    // Tiles past the map edge behave as solid wall.
    wall     = (tile_x >= MDIM) || (tile_y >= MDIM) || wall_map[idx];
    step_now = (tmr == T_LAST);
    {nx, ny} = step_pos(x, y, dir, STEP);
    oof      = (nx >= FMAX) || (ny >= FMAX);
`ifdef BULLET_RICOCHET_EN
    {bx, by} = step_pos(x, y, dir_rev(dir), STEP);
    // A bounce that would push the bullet out of the field retires it instead.
    bounce   = run && !tgt_hit && wall && !flag && (bx < FMAX) && (by < FMAX);
    retire   = run && (tgt_hit || (wall && !bounce) || (!wall && step_now && oof));
`else
    retire   = run && (tgt_hit || wall || (step_now && oof));
`endif
    fly_nxt  = !reset && (grant || ((st == S_FLY) && !retire));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_IDLE; x <= '0; y <= '0; dir <= DIR_UP; tmr <= '0; flag <= 1'b0;
    end else if (grant) begin
      st <= S_FLY; x <= init_x; y <= init_y; dir <= init_dir; tmr <= '0; flag <= 1'b0;
    end else if (run) begin
      if (retire) st <= S_IDLE;
`ifdef BULLET_RICOCHET_EN
      else if (bounce) begin
        dir  <= dir_rev(dir);
        flag <= 1'b1;
        x    <= bx[COORD_W-1:0];
        y    <= by[COORD_W-1:0];
        tmr  <= '0;
      end
`endif
      else if (step_now) begin
        tmr <= '0;
        x   <= nx[COORD_W-1:0];
        y   <= ny[COORD_W-1:0];
      end else tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    word         = '0;
    word.flag    = flag;
    word.obj     = OBJ_BULLET;
    word.active  = (st == S_FLY);
    word.x       = x;
    word.y       = y;
    word.dir     = dir;
    word.rsvd    = 3'b000;
    word.dir_ext = {1'b0, dir};
  end

endmodule

// File: rtl/bullet_pool.sv
// Projectile pool top: lowest-free-slot arbiter, fire cooldown, hit merge, live count.
// Optional BULLET_RICOCHET_EN enables one wall bounce per bullet (in bullet_slot).
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int MAX_BULLETS = 8,
  parameter int NUM_TARGETS = 2,
  parameter int STEP_PERIOD = 3,
  parameter int STEP_PX     = 32,
  parameter int TILE_LOG2   = 5,
  parameter int MAP_DIM     = 16,
  parameter int FIELD_MAX   = 480,
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8,
  parameter int COOLDOWN    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               game_over,
  bullet_pool_if.slave                       fire_bus,
  input  logic [NUM_TARGETS*COORD_W-1:0]     tgt_x,
  input  logic [NUM_TARGETS*COORD_W-1:0]     tgt_y,
  input  logic [MAP_DIM*MAP_DIM-1:0]         wall_map,
  output logic [NUM_TARGETS-1:0]             hit,
  output logic [$clog2(MAX_BULLETS+1)-1:0]   active_count,
  output logic [MAX_BULLETS*32-1:0]          bullet_state
);
  localparam int CNT_W = $clog2(MAX_BULLETS + 1);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  obj_state_t [MAX_BULLETS-1:0]                  words;
  logic [MAX_BULLETS-1:0][NUM_TARGETS-1:0]       hit_vec;
  logic [MAX_BULLETS-1:0]                        fly_nxt, gnt, grant;
  logic [CD_W-1:0]                               cooldown;
  logic                                          any_idle, accept;
  logic [NUM_TARGETS-1:0]                        hit_any;
  logic [CNT_W-1:0]                              count_nxt;

  // Grants look at registered slot state, so a slot retiring this cycle is
  // only grantable from the next cycle on.
  always_comb begin
    gnt      = '0;
    any_idle = 1'b0;
    for (int k = 0; k < MAX_BULLETS; k++) begin
      if (!words[k].active && !any_idle) begin
        gnt[k]   = 1'b1;
        any_idle = 1'b1;
      end
    end
    accept    = fire_bus.fire && !game_over && (cooldown == '0) && any_idle;
    grant     = accept ? gnt : '0;
    hit_any   = '0;
    count_nxt = '0;
    for (int k = 0; k < MAX_BULLETS; k++) begin
      hit_any   = hit_any | hit_vec[k];
      count_nxt = count_nxt + CNT_W'(fly_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_bus.fire_ack <= 1'b0;
      cooldown          <= '0;
      hit               <= '0;
      active_count      <= '0;
    end else begin
      fire_bus.fire_ack <= accept;
      hit               <= hit_any;
      active_count      <= count_nxt;
      if (accept) cooldown <= CD_W'(COOLDOWN);
      else if (!game_over && cooldown != '0) cooldown <= cooldown - 1'b1;
    end
  end

  for (genvar k = 0; k < MAX_BULLETS; k++) begin : g_slot
    bullet_slot #(
      .NUM_TARGETS (NUM_TARGETS),
      .STEP_PERIOD (STEP_PERIOD),
      .STEP_PX     (STEP_PX),
      .TILE_LOG2   (TILE_LOG2),
      .MAP_DIM     (MAP_DIM),
      .FIELD_MAX   (FIELD_MAX),
      .TANK_SIZE   (TANK_SIZE),
      .BULLET_SIZE (BULLET_SIZE)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .game_over (game_over),
      .grant     (grant[k]),
      .init_dir  (dir_e'(fire_bus.fire_dir)),
      .init_x    (fire_bus.init_x),
      .init_y    (fire_bus.init_y),
      .tgt_x     (tgt_x),
      .tgt_y     (tgt_y),
      .wall_map  (wall_map),
      .hit_vec   (hit_vec[k]),
      .fly_nxt   (fly_nxt[k]),
      .word      (words[k])
    );
  end

  assign bullet_state = words;

endmodule
